// File: rtl/pwr_cond_xor_pipe.sv
// pwr_cond_xor_pipe: two-stage elastic pipeline computing y = a ^ (c & d & (a | b))
// per lane, with stage registers that hold when idle and a saturating output
// toggle / transfer counter pair for switching-activity estimation.
module pwr_cond_xor_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  input  logic             cnt_clear_i,
  output logic [CNT_W-1:0] toggle_cnt_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_y_q, s2_y_d;
  logic [WIDTH-1:0] last_y_q, last_y_d;
  logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic             s2_can_accept;
  logic             s1_advance;
  logic             in_hs;
  logic             out_hs;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] y_diff;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] tog_base;
  logic [CNT_W-1:0] xfer_base;
  logic [CNT_W:0]   tog_sum;
  logic [CNT_W:0]   xfer_sum;

  // Handshake qualifiers; in_ready is deliberately combinational from out_ready
  // so a draining S2 lets S1 refill in the same cycle.
  assign s2_can_accept = !s2_v_q || out_ready_i;
  assign s1_advance    = s1_v_q && s2_can_accept;
  assign in_ready_o    = !s1_v_q || s2_can_accept;
  assign in_hs         = in_valid_i && in_ready_o;
  assign out_hs        = s2_v_q && out_ready_i;

  assign g_in   = c_i & d_i & (a_i | b_i);
  assign y_diff = s2_y_q ^ last_y_q;

  assign out_valid_o  = s2_v_q;
  assign y_o          = s2_y_q;
  assign toggle_cnt_o = toggle_cnt_q;
  assign xfer_cnt_o   = xfer_cnt_q;

  // Population count of the bits that differ from the previously accepted result.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNT_W'(y_diff[i]);
    end
  end

  // Saturating adds; a clear on a handshake edge restarts the sums from zero
  // so the current transfer is still counted.
  always_comb begin
    tog_base  = cnt_clear_i ? '0 : toggle_cnt_q;
    xfer_base = cnt_clear_i ? '0 : xfer_cnt_q;
    tog_sum   = {1'b0, tog_base} + {1'b0, pop};
    xfer_sum  = {1'b0, xfer_base} + (CNT_W+1)'(1);
  end

  // Next-state: data registers only load on their transfer, otherwise hold.
  always_comb begin
    s1_v_d       = s1_v_q;
    s1_a_d       = s1_a_q;
    s1_g_d       = s1_g_q;
    s2_v_d       = s2_v_q;
    s2_y_d       = s2_y_q;
    last_y_d     = last_y_q;
    toggle_cnt_d = toggle_cnt_q;
    xfer_cnt_d   = xfer_cnt_q;

    if (in_hs) begin
      s1_v_d = 1'b1;
      s1_a_d = a_i;
      s1_g_d = g_in;
    end else if (s1_advance) begin
      s1_v_d = 1'b0;
    end

    if (s1_advance) begin
      s2_v_d = 1'b1;
      s2_y_d = s1_a_q ^ s1_g_q;
    end else if (out_hs) begin
      s2_v_d = 1'b0;
    end

    if (out_hs) begin
      last_y_d     = s2_y_q;
      toggle_cnt_d = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
      xfer_cnt_d   = xfer_sum[CNT_W] ? '1 : xfer_sum[CNT_W-1:0];
    end else if (cnt_clear_i) begin
      toggle_cnt_d = '0;
      xfer_cnt_d   = '0;
    end
  end

  // State registers; reset drops any in-flight data and zeroes all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      s1_a_q       <= '0;
      s1_g_q       <= '0;
      s2_v_q       <= 1'b0;
      s2_y_q       <= '0;
      last_y_q     <= '0;
      toggle_cnt_q <= '0;
      xfer_cnt_q   <= '0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_a_q       <= s1_a_d;
      s1_g_q       <= s1_g_d;
      s2_v_q       <= s2_v_d;
      s2_y_q       <= s2_y_d;
      last_y_q     <= last_y_d;
      toggle_cnt_q <= toggle_cnt_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_pwr_cond_xor_pipe.sv
// Bench for pwr_cond_xor_pipe: a WIDTH=4/CNT_W=16 instance for the datapath,
// flow-control and reset cases, and a WIDTH=4/CNT_W=4 instance for saturation.
module tb_pwr_cond_xor_pipe;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] y;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_rst_n, m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_cnt_clear;
  logic [3:0]  m_a, m_b, m_c, m_d, m_y;
  logic [15:0] m_tog, m_xfer;

  logic        s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clear;
  logic [3:0]  s_a, s_b, s_c, s_d, s_y;
  logic [3:0]  s_tog, s_xfer;

  pwr_cond_xor_pipe #(.WIDTH(4), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(m_rst_n),
    .in_valid_i(m_in_valid), .in_ready_o(m_in_ready),
    .a_i(m_a), .b_i(m_b), .c_i(m_c), .d_i(m_d),
    .out_valid_o(m_out_valid), .out_ready_i(m_out_ready), .y_o(m_y),
    .cnt_clear_i(m_cnt_clear), .toggle_cnt_o(m_tog), .xfer_cnt_o(m_xfer)
  );

  pwr_cond_xor_pipe #(.WIDTH(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(s_rst_n),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .a_i(s_a), .b_i(s_b), .c_i(s_c), .d_i(s_d),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .y_o(s_y),
    .cnt_clear_i(s_cnt_clear), .toggle_cnt_o(s_tog), .xfer_cnt_o(s_xfer)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_m(input vec_t v);
    m_a = v.a; m_b = v.b; m_c = v.c; m_d = v.d;
  endtask

  task automatic single_op(input string tag, input vec_t v);
    @(negedge clk);
    drive_m(v); m_in_valid = 1'b1; m_out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(m_in_ready), 32'd1);
    @(negedge clk);
    m_in_valid = 1'b0;
    #1 chk({tag, "_out_valid_early"}, 32'(m_out_valid), 32'd0);
    @(negedge clk);
    #1 chk({tag, "_out_valid"}, 32'(m_out_valid), 32'd1);
    chk({tag, "_y"}, 32'(m_y), 32'(v.y));
    @(negedge clk);
    #1 chk({tag, "_drained"}, 32'(m_out_valid), 32'd0);
    chk({tag, "_toggle"}, 32'(m_tog), 32'd1);
    chk({tag, "_xfer"}, 32'(m_xfer), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    // Hand-computed y = a ^ (c & d & (a | b))
    tbl[0] = '{a:4'b0101, b:4'b0011, c:4'b1111, d:4'b1111, y:4'b0010};
    tbl[1] = '{a:4'b1111, b:4'b0000, c:4'b1010, d:4'b1100, y:4'b0111};
    tbl[2] = '{a:4'b0000, b:4'b1111, c:4'b1111, d:4'b1111, y:4'b1111};
    tbl[3] = '{a:4'b0000, b:4'b0000, c:4'b1111, d:4'b1111, y:4'b0000};
    tbl[4] = '{a:4'b1100, b:4'b0011, c:4'b0110, d:4'b1111, y:4'b1010};
    tbl[5] = '{a:4'b1010, b:4'b0101, c:4'b0000, d:4'b1111, y:4'b1010};
    tbl[6] = '{a:4'b0011, b:4'b0100, c:4'b1111, d:4'b0101, y:4'b0110};
    tbl[7] = '{a:4'b1001, b:4'b0000, c:4'b1001, d:4'b1011, y:4'b0000};

    m_rst_n = 1'b0; m_in_valid = 1'b0; m_out_ready = 1'b0; m_cnt_clear = 1'b0;
    m_a = '0; m_b = '0; m_c = '0; m_d = '0;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_cnt_clear = 1'b0;
    s_a = '0; s_b = '0; s_c = '0; s_d = '0;

    repeat (2) @(negedge clk);
    #1 chk("rst_in_ready", 32'(m_in_ready), 32'd1);
    chk("rst_out_valid", 32'(m_out_valid), 32'd0);
    chk("rst_y", 32'(m_y), 32'd0);
    chk("rst_toggle", 32'(m_tog), 32'd0);
    chk("rst_xfer", 32'(m_xfer), 32'd0);
    @(negedge clk);
    m_rst_n = 1'b1; s_rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(m_in_ready), 32'd1);

    // Single operation
    single_op("single", tbl[0]);

    // Streaming: one accept and one result per cycle
    m_out_ready = 1'b1;
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      if (t < 8) begin
        drive_m(tbl[t]); m_in_valid = 1'b1;
      end else begin
        m_in_valid = 1'b0;
      end
      #1;
      if (t < 8) chk("stream_in_ready", 32'(m_in_ready), 32'd1);
      if (t >= 2 && t < 10) begin
        chk("stream_out_valid", 32'(m_out_valid), 32'd1);
        chk("stream_y", 32'(m_y), 32'(tbl[t-2].y));
      end
    end
    // toggles: 1 (single) + 0+2+1+4+2+0+2+2 = 14
    chk("stream_toggle", 32'(m_tog), 32'd14);
    chk("stream_xfer", 32'(m_xfer), 32'd9);

    // Backpressure: two accepts fill the pipe, third offer stalls
    m_out_ready = 1'b0;
    @(negedge clk);
    drive_m(tbl[1]); m_in_valid = 1'b1;
    #1 chk("bp_ready_0", 32'(m_in_ready), 32'd1);
    @(negedge clk);
    drive_m(tbl[2]);
    #1 chk("bp_ready_1", 32'(m_in_ready), 32'd1);
    @(negedge clk);
    drive_m(tbl[4]);
    #1 chk("bp_ready_2", 32'(m_in_ready), 32'd0);
    chk("bp_out_valid", 32'(m_out_valid), 32'd1);
    chk("bp_y", 32'(m_y), 32'(tbl[1].y));
    repeat (3) begin
      @(negedge clk);
      #1 chk("bp_hold_ready", 32'(m_in_ready), 32'd0);
      chk("bp_hold_y", 32'(m_y), 32'(tbl[1].y));
    end
    @(negedge clk);
    m_out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(m_in_ready), 32'd1);
    chk("bp_release_y", 32'(m_y), 32'(tbl[1].y));
    @(negedge clk);
    m_in_valid = 1'b0;
    #1 chk("bp_drain_y1", 32'(m_y), 32'(tbl[2].y));
    @(negedge clk);
    #1 chk("bp_drain_valid2", 32'(m_out_valid), 32'd1);
    chk("bp_drain_y2", 32'(m_y), 32'(tbl[4].y));
    @(negedge clk);
    #1 chk("bp_empty", 32'(m_out_valid), 32'd0);
    // 0000->0111: 3, 0111->1111: 1, 1111->1010: 2
    chk("bp_toggle", 32'(m_tog), 32'd20);
    chk("bp_xfer", 32'(m_xfer), 32'd12);

    // Isolation: operands wiggle with in_valid low
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      m_in_valid = 1'b0;
      m_a = 4'($urandom); m_b = 4'($urandom); m_c = 4'($urandom); m_d = 4'($urandom);
      #1 chk("iso_y", 32'(m_y), 32'b1010);
      chk("iso_out_valid", 32'(m_out_valid), 32'd0);
    end
    chk("iso_toggle", 32'(m_tog), 32'd20);
    chk("iso_xfer", 32'(m_xfer), 32'd12);

    // Async reset with both stages full
    m_out_ready = 1'b0;
    @(negedge clk);
    drive_m(tbl[0]); m_in_valid = 1'b1;
    @(negedge clk);
    drive_m(tbl[6]);
    @(negedge clk);
    m_in_valid = 1'b0;
    #1 chk("full_out_valid", 32'(m_out_valid), 32'd1);
    chk("full_y", 32'(m_y), 32'(tbl[0].y));
    chk("full_in_ready", 32'(m_in_ready), 32'd0);
    #2 m_rst_n = 1'b0;
    #1 chk("arst_out_valid", 32'(m_out_valid), 32'd0);
    chk("arst_y", 32'(m_y), 32'd0);
    chk("arst_toggle", 32'(m_tog), 32'd0);
    chk("arst_xfer", 32'(m_xfer), 32'd0);
    chk("arst_in_ready", 32'(m_in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    m_rst_n = 1'b1;
    single_op("after_rst", tbl[0]);

    // Saturation on the CNT_W=4 instance: alternate 1111 / 0000
    s_out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t < 5) begin
        s_a = (t % 2 == 0) ? 4'b1111 : 4'b0000;
        s_b = '0; s_c = '0; s_d = '0;
        s_in_valid = 1'b1;
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      if (t == 5) chk("sat_toggle_3", 32'(s_tog), 32'd12);
      if (t == 6) chk("sat_toggle_4", 32'(s_tog), 32'd15);
    end
    chk("sat_toggle_5", 32'(s_tog), 32'd15);
    chk("sat_xfer_5", 32'(s_xfer), 32'd5);

    // Clear coinciding with a handshake that toggles all 4 bits
    s_out_ready = 1'b0;
    @(negedge clk);
    s_a = 4'b0000; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    #1 chk("clr_out_valid", 32'(s_out_valid), 32'd1);
    chk("clr_y", 32'(s_y), 32'd0);
    s_out_ready = 1'b1; s_cnt_clear = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0; s_cnt_clear = 1'b0;
    #1 chk("clr_hs_toggle", 32'(s_tog), 32'd4);
    chk("clr_hs_xfer", 32'(s_xfer), 32'd1);
    chk("clr_hs_drained", 32'(s_out_valid), 32'd0);
    @(negedge clk);
    s_cnt_clear = 1'b1;
    @(negedge clk);
    s_cnt_clear = 1'b0;
    #1 chk("clr_only_toggle", 32'(s_tog), 32'd0);
    chk("clr_only_xfer", 32'(s_xfer), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
